// File: rtl/mix_unpack_pkg.sv
// Shared widths, types and encodings for the mult/div unpack back end.
package mix_unpack_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned AQW = 2 * DW + 1;

    typedef logic [DW-1:0] wsizeN;
    typedef logic [2*DW:0] waqsize;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        FIX  = 2'd2,
        HOLD = 2'd3
    } unpack_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/twos_neg.sv
// Combinational conditional two's-complement negate, modulo 2^W.
module twos_neg #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mix_unpack.sv
// Captures the final A:Q:Q-1 register, splits and sign-corrects it, and
// holds the result under a valid/ack handshake.
module mix_unpack #(
    parameter int unsigned DW = mix_unpack_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          done,
    input  logic          op,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic          div0,
    input  logic [2*DW:0] aq_reg,
    input  logic          res_ack,
    output logic [DW-1:0] result_hi,
    output logic [DW-1:0] result_lo,
    output logic          res_valid,
    output logic          busy,
    output logic          error,
    output logic          overrun
);
    import mix_unpack_pkg::*;

    localparam int unsigned AQ_W = 2 * DW + 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CAPT = CAPT;
    localparam logic [1:0] S_FIX  = FIX;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic            cap_en;
    logic            split_en;
    logic            fix_en;
    logic            ovr_set;
    logic            ack_take;

    // Guard bit aq_reg[0] is dropped at capture.
    logic [2*DW-1:0] aq_q;
    logic            op_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            div0_q;
    logic [DW-1:0]   mag_hi_q;
    logic [DW-1:0]   mag_lo_q;
    logic [DW-1:0]   fix_hi;
    logic [DW-1:0]   fix_lo;
    logic            guard_unused;

    assign guard_unused = aq_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start overrides every other event in every state.
    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        split_en = 1'b0;
        fix_en   = 1'b0;
        ovr_set  = 1'b0;
        ack_take = 1'b0;
        if (start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (done) begin
                        cap_en  = 1'b1;
                        state_d = S_CAPT;
                    end
                end
                S_CAPT: begin
                    split_en = 1'b1;
                    state_d  = S_FIX;
                end
                S_FIX: begin
                    fix_en  = 1'b1;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    ovr_set = done;
                    if (res_ack) begin
                        ack_take = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Remainder follows the dividend sign; quotient follows sign_a ^ sign_b.
    twos_neg #(.W(DW)) u_neg_hi (
        .din  (mag_hi_q),
        .en   ((op_q == OP_DIV) && sign_a_q),
        .dout (fix_hi)
    );

    twos_neg #(.W(DW)) u_neg_lo (
        .din  (mag_lo_q),
        .en   ((op_q == OP_DIV) && (sign_a_q ^ sign_b_q)),
        .dout (fix_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            aq_q      <= '0;
            op_q      <= OP_MULT;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            div0_q    <= 1'b0;
            mag_hi_q  <= '0;
            mag_lo_q  <= '0;
            result_hi <= '0;
            result_lo <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            if (cap_en) begin
                aq_q     <= aq_reg[AQ_W-1:1];
                op_q     <= op;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                div0_q   <= div0;
            end
            // Product and remainder/quotient share the same bit split.
            if (split_en) begin
                mag_hi_q <= aq_q[2*DW-1:DW];
                mag_lo_q <= aq_q[DW-1:0];
            end
            if (fix_en) begin
                result_hi <= div0_q ? '1 : fix_hi;
                result_lo <= div0_q ? '1 : fix_lo;
            end
            if (start) begin
                res_valid <= 1'b0;
                error     <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (fix_en) begin
                    res_valid <= 1'b1;
                    error     <= div0_q;
                end else if (ack_take) begin
                    res_valid <= 1'b0;
                end
                if (ovr_set) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mix_unpack.sv
// Directed-vector bench for mix_unpack at DW=8.
module tb_mix_unpack;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          done;
    logic          op;
    logic          sign_a;
    logic          sign_b;
    logic          div0;
    logic [2*DW:0] aq_reg;
    logic          res_ack;
    logic [DW-1:0] result_hi;
    logic [DW-1:0] result_lo;
    logic          res_valid;
    logic          busy;
    logic          error;
    logic          overrun;

    int n_cmp;
    int n_err;

    mix_unpack #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .op        (op),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .div0      (div0),
        .aq_reg    (aq_reg),
        .res_ack   (res_ack),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .res_valid (res_valid),
        .busy      (busy),
        .error     (error),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input logic v, input logic e);
        chk({tag, ".hi"}, 32'(result_hi), 32'(hi));
        chk({tag, ".lo"}, 32'(result_lo), 32'(lo));
        chk({tag, ".valid"}, 32'(res_valid), 32'(v));
        chk({tag, ".error"}, 32'(error), 32'(e));
    endtask

    // Present done for one sampling edge.
    task automatic fire(input logic o, input logic sa, input logic sb, input logic d0,
                        input logic [16:0] aq);
        op = o; sign_a = sa; sign_b = sb; div0 = d0; aq_reg = aq; done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic ack();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; done = 1'b0; op = 1'b0; sign_a = 1'b0;
        sign_b = 1'b0; div0 = 1'b0; aq_reg = '0; res_ack = 1'b0;
        tick();
        tick();
        chk_res("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // Multiply -21: three edges from done sampling to valid.
        fire(1'b0, 1'b1, 1'b0, 1'b0, 17'h1FFD6);
        chk("mul.e1.busy", 32'(busy), 32'd1);
        chk("mul.e1.valid", 32'(res_valid), 32'd0);
        tick();
        chk("mul.e2.valid", 32'(res_valid), 32'd0);
        tick();
        chk_res("mul", 8'hFF, 8'hEB, 1'b1, 1'b0);
        ack();
        chk("mul.ack.valid", 32'(res_valid), 32'd0);
        chk("mul.ack.busy", 32'(busy), 32'd0);

        // -7 / 2 -> Q=-3, R=-1.
        fire(1'b1, 1'b1, 1'b0, 1'b0, 17'h00206);
        tick(); tick();
        chk_res("div_m7_2", 8'hFF, 8'hFD, 1'b1, 1'b0);
        tick();
        chk("div_m7_2.hold", 32'(res_valid), 32'd1);
        ack();
        chk("div_m7_2.ack.valid", 32'(res_valid), 32'd0);
        chk("div_m7_2.ack.hi_kept", 32'(result_hi), 32'h0FF);

        // Quotient 0x80 negates to itself; positive dividend keeps remainder.
        fire(1'b1, 1'b0, 1'b1, 1'b0, 17'h00700);
        tick(); tick();
        chk_res("div_neg80", 8'h03, 8'h80, 1'b1, 1'b0);
        ack();

        // Both signs negative: remainder negated, quotient not.
        fire(1'b1, 1'b1, 1'b1, 1'b0, 17'h00A0E);
        tick(); tick();
        chk_res("div_nn", 8'hFB, 8'h07, 1'b1, 1'b0);
        ack();

        // Divide by zero; error persists past ack.
        fire(1'b1, 1'b0, 1'b0, 1'b1, 17'h12345);
        tick(); tick();
        chk_res("div0", 8'hFF, 8'hFF, 1'b1, 1'b1);
        ack();
        chk("div0.ack.valid", 32'(res_valid), 32'd0);
        chk("div0.ack.error", 32'(error), 32'd1);

        // Overrun: done during HOLD is dropped but flagged.
        fire(1'b0, 1'b0, 1'b0, 1'b0, 17'h02468);
        tick(); tick();
        chk_res("ovr.first", 8'h12, 8'h34, 1'b1, 1'b0);
        fire(1'b1, 1'b1, 1'b1, 1'b1, 17'h1FFFF);
        chk("ovr.flag", 32'(overrun), 32'd1);
        tick(); tick();
        chk_res("ovr.kept", 8'h12, 8'h34, 1'b1, 1'b0);
        chk("ovr.sticky", 32'(overrun), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr.start.overrun", 32'(overrun), 32'd0);
        chk("ovr.start.valid", 32'(res_valid), 32'd0);
        chk("ovr.start.busy", 32'(busy), 32'd0);
        chk("ovr.start.hi_kept", 32'(result_hi), 32'h012);

        // Abort in FIX: no valid ever appears.
        fire(1'b1, 1'b1, 1'b1, 1'b0, 17'h00A0E);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort.valid", 32'(res_valid), 32'd0);
            tick();
        end

        // Reset in CAPT clears everything; next operation completes.
        fire(1'b1, 1'b0, 1'b0, 1'b1, 17'h00A0E);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_res("rst_capt", 8'h00, 8'h00, 1'b0, 1'b0);
        chk("rst_capt.busy", 32'(busy), 32'd0);
        tick(); tick();
        chk("rst_capt.no_valid", 32'(res_valid), 32'd0);
        fire(1'b1, 1'b1, 1'b1, 1'b0, 17'h00A0E);
        tick(); tick();
        chk_res("after_rst", 8'hFB, 8'h07, 1'b1, 1'b0);
        ack();

        // done together with start is dropped.
        op = 1'b0; aq_reg = 17'h00002; done = 1'b1; start = 1'b1;
        tick();
        done = 1'b0; start = 1'b0;
        chk("dstart.busy", 32'(busy), 32'd0);
        tick(); tick();
        chk("dstart.valid", 32'(res_valid), 32'd0);
        chk("dstart.lo_kept", 32'(result_lo), 32'h007);

        // Ack on the first HOLD cycle: valid high for exactly one cycle.
        fire(1'b0, 1'b0, 1'b0, 1'b0, 17'h0ABCD);
        tick(); tick();
        chk_res("ack1", 8'h55, 8'hE6, 1'b1, 1'b0);
        ack();
        chk("ack1.drop", 32'(res_valid), 32'd0);
        tick();
        chk("ack1.stay_low", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
